// File: rtl/sdram_cmd_monitor_if.sv
// SDRAM command bus as seen by the passive monitor, plus the monitor's status outputs.
// The master side drives the bus; the monitor (slave) only observes it.
interface sdram_cmd_monitor_if #(
   parameter int ERR_CNT_W = 8
);
   logic [11:0]          SA;
   logic [1:0]           BA;
   logic [1:0]           CS_N;
   logic                 CKE;
   logic                 RAS_N;
   logic                 CAS_N;
   logic                 WE_N;
   logic [1:0]           DQM;
   logic                 Clear_Errors;

   logic                 Cmd_Valid;
   logic [2:0]           Cmd_Code;
   logic [11:0]          Mode_Reg;
   logic                 Mode_Valid;
   logic [3:0]           Burst_Len;
   logic [1:0]           Cas_Lat;
   logic [3:0]           Bank_Open;
   logic [4:0]           Err_Flags;
   logic [ERR_CNT_W-1:0] Err_Count;
   logic                 Masked_Write;

   modport master (
      output SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM, Clear_Errors,
      input  Cmd_Valid, Cmd_Code, Mode_Reg, Mode_Valid, Burst_Len, Cas_Lat,
             Bank_Open, Err_Flags, Err_Count, Masked_Write
   );

   modport slave (
      input  SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM, Clear_Errors,
      output Cmd_Valid, Cmd_Code, Mode_Reg, Mode_Valid, Burst_Len, Cas_Lat,
             Bank_Open, Err_Flags, Err_Count, Masked_Write
   );
endinterface

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command decoder: bank tracking, mode capture, tMRD/tRCD/bank-state checks.
// Latency 1 cycle on every output; never drives the bus and applies no backpressure.
module sdram_cmd_monitor #(
   parameter int TMRD      = 2,
   parameter int TRCD      = 2,
   parameter int ERR_CNT_W = 8
) (
   input logic           clk,
   input logic           Reset,
   sdram_cmd_monitor_if.slave bus
);
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_LMR = 3'b000;

   localparam logic [2:0] TMRD_LD = 3'(TMRD - 1);
   localparam logic [2:0] TRCD_LD = 3'(TRCD - 1);

   typedef enum logic {MODE_IDLE, MODE_WAIT} mode_st_e;

   mode_st_e             mode_st_q, mode_st_d;
   logic [2:0]           tmrd_q, tmrd_d;
   logic [3:0][2:0]      trcd_q, trcd_d;
   logic [3:0]           bank_open_q, bank_open_d;
   logic [11:0]          mode_reg_q, mode_reg_d;
   logic                 mode_valid_q, mode_valid_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic [2:0]           cmd_code_q, cmd_code_d;
   logic [4:0]           err_flags_q, err_flags_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic                 masked_q, masked_d;

   logic [2:0] code;
   logic       cmd_vld;
   logic [4:0] err;

   assign code    = {bus.RAS_N, bus.CAS_N, bus.WE_N};
   assign cmd_vld = bus.CKE && (bus.CS_N != 2'b11) && (code != CMD_NOP);

   always_comb begin
      mode_st_d    = mode_st_q;
      tmrd_d       = tmrd_q;
      trcd_d       = trcd_q;
      bank_open_d  = bank_open_q;
      mode_reg_d   = mode_reg_q;
      mode_valid_d = mode_valid_q;
      cmd_code_d   = cmd_code_q;
      cmd_valid_d  = cmd_vld;
      masked_d     = 1'b0;
      err_flags_d  = err_flags_q;
      err_count_d  = err_count_q;
      err          = '0;

      // Timing counters only advance on cycles the SDRAM actually sees a clock.
      if (bus.CKE) begin
         for (int b = 0; b < 4; b++) begin
            if (trcd_q[b] != 3'd0) trcd_d[b] = trcd_q[b] - 3'd1;
         end
         if (mode_st_q == MODE_WAIT) begin
            tmrd_d = tmrd_q - 3'd1;
            if (tmrd_q == 3'd1) mode_st_d = MODE_IDLE;
         end
      end

      if (cmd_vld) begin
         cmd_code_d = code;
         if (mode_st_q == MODE_WAIT) err[2] = 1'b1;
         case (code)
            CMD_ACT: begin
               err[1]              = bank_open_q[bus.BA];
               bank_open_d[bus.BA] = 1'b1;
               trcd_d[bus.BA]      = TRCD_LD;
            end
            CMD_RD, CMD_WR: begin
               err[0] = !bank_open_q[bus.BA];
               err[4] = (trcd_q[bus.BA] != 3'd0);
               if (bus.SA[10]) bank_open_d[bus.BA] = 1'b0;
               masked_d = (code == CMD_WR) && (bus.DQM == 2'b11);
            end
            CMD_PRE: begin
               if (bus.SA[10]) bank_open_d = '0;
               else            bank_open_d[bus.BA] = 1'b0;
            end
            CMD_REF: err[3] = |bank_open_q;
            CMD_LMR: begin
               err[3]       = |bank_open_q;
               mode_reg_d   = bus.SA;
               mode_valid_d = 1'b1;
               tmrd_d       = TMRD_LD;
               mode_st_d    = (TMRD_LD != 3'd0) ? MODE_WAIT : MODE_IDLE;
            end
            default: ;
         endcase
      end

      // A violation coincident with a clear survives it as a fresh count of one.
      if (bus.Clear_Errors) begin
         err_flags_d = err;
         err_count_d = (|err) ? ERR_CNT_W'(1) : '0;
      end else if (|err) begin
         err_flags_d = err_flags_q | err;
         if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         mode_st_q    <= MODE_IDLE;
         tmrd_q       <= '0;
         trcd_q       <= '0;
         bank_open_q  <= '0;
         mode_reg_q   <= '0;
         mode_valid_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_code_q   <= CMD_NOP;
         err_flags_q  <= '0;
         err_count_q  <= '0;
         masked_q     <= 1'b0;
      end else begin
         mode_st_q    <= mode_st_d;
         tmrd_q       <= tmrd_d;
         trcd_q       <= trcd_d;
         bank_open_q  <= bank_open_d;
         mode_reg_q   <= mode_reg_d;
         mode_valid_q <= mode_valid_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_code_q   <= cmd_code_d;
         err_flags_q  <= err_flags_d;
         err_count_q  <= err_count_d;
         masked_q     <= masked_d;
      end
   end

   always_comb begin
      case (mode_reg_q[2:0])
         3'd0:    bus.Burst_Len = 4'd1;
         3'd1:    bus.Burst_Len = 4'd2;
         3'd2:    bus.Burst_Len = 4'd4;
         3'd3:    bus.Burst_Len = 4'd8;
         default: bus.Burst_Len = 4'd0;
      endcase
   end

   assign bus.Cas_Lat      = mode_reg_q[5:4];
   assign bus.Cmd_Valid    = cmd_valid_q;
   assign bus.Cmd_Code     = cmd_code_q;
   assign bus.Mode_Reg     = mode_reg_q;
   assign bus.Mode_Valid   = mode_valid_q;
   assign bus.Bank_Open    = bank_open_q;
   assign bus.Err_Flags    = err_flags_q;
   assign bus.Err_Count    = err_count_q;
   assign bus.Masked_Write = masked_q;
endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed bench for sdram_cmd_monitor: expected outputs queued per command, compared one cycle later.
module tb_sdram_cmd_monitor;
   localparam logic [2:0] NOP = 3'b111;
   localparam logic [2:0] ACT = 3'b011;
   localparam logic [2:0] RD  = 3'b101;
   localparam logic [2:0] WR  = 3'b100;
   localparam logic [2:0] BST = 3'b110;
   localparam logic [2:0] PRE = 3'b010;
   localparam logic [2:0] REF = 3'b001;
   localparam logic [2:0] LMR = 3'b000;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   sdram_cmd_monitor_if #(.ERR_CNT_W(8)) bus ();

   sdram_cmd_monitor #(.TMRD(2), .TRCD(2), .ERR_CNT_W(8)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic        cv;
      logic [2:0]  code;
      logic [11:0] mode;
      logic        mv;
      logic [3:0]  bl;
      logic [1:0]  cl;
      logic [3:0]  open;
      logic [4:0]  flags;
      logic [7:0]  cnt;
      logic        mw;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic [2:0]  e_code;
   logic [11:0] e_mode;
   logic        e_mv;
   logic [3:0]  e_bl;
   logic [1:0]  e_cl;
   logic [3:0]  e_open;
   logic [4:0]  e_flags;
   logic [7:0]  e_cnt;

   task automatic chk(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk(e.tag, "Cmd_Valid",    16'(bus.Cmd_Valid),    16'(e.cv));
         chk(e.tag, "Cmd_Code",     16'(bus.Cmd_Code),     16'(e.code));
         chk(e.tag, "Mode_Reg",     16'(bus.Mode_Reg),     16'(e.mode));
         chk(e.tag, "Mode_Valid",   16'(bus.Mode_Valid),   16'(e.mv));
         chk(e.tag, "Burst_Len",    16'(bus.Burst_Len),    16'(e.bl));
         chk(e.tag, "Cas_Lat",      16'(bus.Cas_Lat),      16'(e.cl));
         chk(e.tag, "Bank_Open",    16'(bus.Bank_Open),    16'(e.open));
         chk(e.tag, "Err_Flags",    16'(bus.Err_Flags),    16'(e.flags));
         chk(e.tag, "Err_Count",    16'(bus.Err_Count),    16'(e.cnt));
         chk(e.tag, "Masked_Write", 16'(bus.Masked_Write), 16'(e.mw));
      end
   endtask

   // One bus cycle: drive at negedge, queue the expectation, compare just after the sampling edge.
   task automatic step(input string tag, input logic [2:0] code, input logic [1:0] ba,
                       input logic [11:0] sa, input logic [1:0] dqm, input logic cke,
                       input logic [1:0] cs, input logic clr, input logic rst);
      exp_t e;
      logic cv;
      @(negedge clk);
      Reset            = rst;
      bus.SA           = sa;
      bus.BA           = ba;
      bus.DQM          = dqm;
      bus.CKE          = cke;
      bus.CS_N         = cs;
      bus.Clear_Errors = clr;
      {bus.RAS_N, bus.CAS_N, bus.WE_N} = code;
      cv = !rst && cke && (cs != 2'b11) && (code != NOP);
      if (rst)     e_code = NOP;
      else if (cv) e_code = code;
      e.tag   = tag;
      e.cv    = cv;
      e.code  = e_code;
      e.mode  = e_mode;
      e.mv    = e_mv;
      e.bl    = e_bl;
      e.cl    = e_cl;
      e.open  = e_open;
      e.flags = e_flags;
      e.cnt   = e_cnt;
      e.mw    = cv && (code == WR) && (dqm == 2'b11);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic cmd(input string tag, input logic [2:0] code, input logic [1:0] ba, input logic [11:0] sa);
      step(tag, code, ba, sa, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0);
   endtask

   task automatic clear_nop(input string tag);
      e_flags = '0;
      e_cnt   = '0;
      step(tag, NOP, 2'd0, 12'h000, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
   endtask

   initial begin
      Reset = 1'b1;
      bus.SA = '0; bus.BA = '0; bus.DQM = '0; bus.CKE = 1'b1; bus.CS_N = 2'b11;
      bus.RAS_N = 1'b1; bus.CAS_N = 1'b1; bus.WE_N = 1'b1; bus.Clear_Errors = 1'b0;
      e_code = NOP; e_mode = '0; e_mv = 1'b0; e_bl = 4'd1; e_cl = 2'd0;
      e_open = '0; e_flags = '0; e_cnt = '0;

      step("reset0", NOP, 2'd0, 12'h000, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1);
      step("reset1", LMR, 2'd0, 12'h0FF, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1);

      // Mode capture and decode.
      e_mode = 12'h030; e_mv = 1'b1; e_bl = 4'd1; e_cl = 2'd3;
      cmd("lmr030", LMR, 2'd0, 12'h030);
      cmd("nop_a", NOP, 2'd0, 12'h000);
      cmd("nop_b", NOP, 2'd0, 12'h000);

      // ACTIVE one cycle after LOAD MODE violates tMRD.
      cmd("lmr030b", LMR, 2'd0, 12'h030);
      e_open = 4'b0100; e_flags = 5'b00100; e_cnt = 8'd1;
      cmd("act_tmrd", ACT, 2'd2, 12'h000);
      clear_nop("clr1");
      e_open = 4'b0000;
      cmd("pre_b2", PRE, 2'd2, 12'h000);

      // Bank state and tRCD.
      e_open = 4'b0010;
      cmd("act_b1", ACT, 2'd1, 12'h000);
      cmd("nop_c", NOP, 2'd0, 12'h000);
      cmd("rd_b1", RD, 2'd1, 12'h000);
      e_flags = 5'b00001; e_cnt = 8'd1;
      cmd("rd_closed", RD, 2'd2, 12'h000);
      clear_nop("clr2");
      e_open = 4'b0011;
      cmd("act_b0", ACT, 2'd0, 12'h000);
      e_flags = 5'b10000; e_cnt = 8'd1;
      cmd("rd_trcd", RD, 2'd0, 12'h000);
      clear_nop("clr3");
      e_open = 4'b0001;
      step("wr_masked_ap", WR, 2'd1, 12'h400, 2'b11, 1'b1, 2'b10, 1'b0, 1'b0);

      // Mode reload / refresh with banks open, then precharge-all.
      e_open = 4'b1001;
      cmd("act_b3", ACT, 2'd3, 12'h000);
      cmd("nop_d", NOP, 2'd0, 12'h000);
      e_mode = 12'h037; e_bl = 4'd0; e_cl = 2'd3; e_flags = 5'b01000; e_cnt = 8'd1;
      cmd("lmr_open", LMR, 2'd0, 12'h037);
      cmd("nop_e", NOP, 2'd0, 12'h000);
      cmd("nop_f", NOP, 2'd0, 12'h000);
      e_cnt = 8'd2;
      cmd("ref_open", REF, 2'd0, 12'h000);
      e_open = 4'b0000;
      cmd("pre_all", PRE, 2'd1, 12'h400);
      cmd("ref_closed", REF, 2'd0, 12'h000);
      cmd("bst", BST, 2'd0, 12'h000);

      // Counter saturation, then clear coincident with a violation.
      clear_nop("clr4");
      e_open = 4'b0001;
      cmd("act0", ACT, 2'd0, 12'h000);
      cmd("nop_g", NOP, 2'd0, 12'h000);
      e_flags = 5'b00010;
      for (int i = 1; i <= 300; i++) begin
         e_cnt = (i > 255) ? 8'd255 : 8'(i);
         cmd($sformatf("sat%0d", i), ACT, 2'd0, 12'h000);
      end
      e_cnt = 8'd1; e_flags = 5'b00010;
      step("clr_viol", ACT, 2'd0, 12'h000, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);

      // Deselect / clock-disable: no decode, tMRD frozen while CKE=0.
      e_flags = '0; e_cnt = '0; e_open = 4'b0000;
      step("clr_pre", PRE, 2'd0, 12'h400, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
      e_mode = 12'h021; e_bl = 4'd2; e_cl = 2'd2;
      cmd("lmr021", LMR, 2'd0, 12'h021);
      step("cke0_lmr", LMR, 2'd0, 12'h0FF, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
      e_open = 4'b0001; e_flags = 5'b00100; e_cnt = 8'd1;
      cmd("act_frozen", ACT, 2'd0, 12'h000);
      step("cs11_lmr", LMR, 2'd0, 12'h0FF, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);

      // Reset in the middle of a tMRD wait.
      e_mode = 12'h055; e_bl = 4'd0; e_cl = 2'd1; e_flags = 5'b01100; e_cnt = 8'd2;
      cmd("lmr055", LMR, 2'd0, 12'h055);
      e_mode = '0; e_mv = 1'b0; e_bl = 4'd1; e_cl = 2'd0; e_open = '0; e_flags = '0; e_cnt = '0;
      step("rst_wait", ACT, 2'd1, 12'h000, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1);
      e_open = 4'b0010;
      cmd("act_after_rst", ACT, 2'd1, 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdram_cmd_monitor.md
Name: sdram_cmd_monitor

Overview:
- Passive receiver for the SDRAM command bus driven by the SDRAM arbiter (SA/BA/CS_N/CKE/RAS_N/CAS_N/WE_N/DQM).
- Decodes every command and captures the last LOAD MODE word.
- Tracks the open/closed state of each bank.
- Flags protocol violations around the Nios/camera context switches (mode reload, tMRD, tRCD, access to a closed bank). Never drives the SDRAM bus; used for on-chip debug and bench checking.

Parameters:
TMRD, 2, minimum cycles from LOAD MODE to next non-NOP command (1..7)
TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank (1..7)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, all sampling on rising edge
Reset  input  1  synchronous, active-high reset
SA  input  12  SDRAM address bus
BA  input  2  SDRAM bank address
CS_N  input  2  chip selects, active low
CKE  input  1  clock enable
RAS_N  input  1  row address strobe
CAS_N  input  1  column address strobe
WE_N  input  1  write enable
DQM  input  2  data masks (monitored only for WRITE with DQM=2'b11, counted as a masked write, no error)
Clear_Errors  input  1  one-cycle pulse; clears sticky flags and counter
Cmd_Valid  output  1  registered; decoded non-NOP command seen last cycle
Cmd_Code  output  3  registered {RAS_N,CAS_N,WE_N} of that command
Mode_Reg  output  12  last LOAD MODE SA value
Mode_Valid  output  1  set after first LOAD MODE since reset
Burst_Len  output  4  decoded from Mode_Reg[2:0]: 0→1, 1→2, 2→4, 3→8, 7→0 (full page), others→0
Cas_Lat  output  2  Mode_Reg[5:4]
Bank_Open  output  4  one bit per bank, 1 = row open
Err_Flags  output  5  sticky: [0] RW to closed bank, [1] ACTIVE to open bank, [2] tMRD violation, [3] LOAD MODE/REFRESH with any bank open, [4] tRCD violation
Err_Count  output  ERR_CNT_W  saturating count of violating commands
Masked_Write  output  1  registered pulse for WRITE with DQM=2'b11

Behaviour:
- Command is sampled when CKE=1 and CS_N!=2'b11; otherwise treated as NOP/deselect. CKE=0 freezes all timing counters.
- Encoding {RAS_N,CAS_N,WE_N}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE, 001 REFRESH, 000 LOAD MODE.
- All outputs are registered: effects appear the cycle after the sampling edge (latency 1). Cmd_Valid, Masked_Write are single-cycle pulses.
- Reset values: Cmd_Valid 0, Cmd_Code 3'b111, Mode_Reg 0, Mode_Valid 0, Bank_Open 0, Err_Flags 0, Err_Count 0, Masked_Write 0. The tMRD and tRCD counters load "expired".
- ACTIVE: checked against the pre-command Bank_Open; sets Bank_Open[BA]; loads tRCD counter[BA]=TRCD-1.
- PRECHARGE: SA[10]=1 clears all banks, else clears Bank_Open[BA]. No error on a closed bank.
- READ/WRITE: error[0] if bank closed; error[4] if tRCD counter[BA]!=0. Auto-precharge (SA[10]=1) clears Bank_Open[BA] after the check.
- LOAD MODE: captures SA into Mode_Reg; sets Mode_Valid; loads tMRD counter=TMRD-1. Error[3] if any Bank_Open bit set (capture still occurs).
- REFRESH: error[3] if any bank open.
- tMRD: any non-NOP command while the tMRD counter !=0 → error[2]. The counter decrements each CKE=1 cycle to 0.
- Per-command errors are ORed: one violating command increments Err_Count by exactly 1, even with multiple bits set. Saturates at all-ones.
- Clear_Errors in the same cycle as a violation: the violation wins; Err_Flags = the new bits only, Err_Count = 1.
- Reset mid-operation discards all bank and timing state; Reset has priority over all inputs.
- Monitor state machine per bank: CLOSED → (ACTIVE) → OPENING (tRCD counting) → OPEN → (PRECHARGE / auto-precharge) → CLOSED. Global: MODE_IDLE ↔ MODE_WAIT (tMRD counting).

Test Plan:
- Reset, then LOAD MODE SA=12'h030, followed by NOP, NOP → Mode_Reg=12'h030, Mode_Valid=1, Burst_Len=1, Cas_Lat=3, Err_Flags=0.
- LOAD MODE immediately followed by ACTIVE (TMRD=2) → Err_Flags[2]=1, Err_Count=1, Bank_Open[BA]=1.
- ACTIVE BA=1, NOP, READ BA=1 → no error; READ BA=2 → Err_Flags[0]=1; READ directly after ACTIVE → Err_Flags[4]=1.
- ACTIVE BA=0 and BA=3, LOAD MODE SA=12'h037 → Err_Flags[3]=1, Mode_Reg=12'h037. Then PRECHARGE SA[10]=1 → Bank_Open=4'b0000.
- 300 consecutive ACTIVE to an open bank → Err_Count holds at 255. Clear_Errors coincident with one more violation → Err_Count=1, Err_Flags=5'b00010.
- CKE=0 or CS_N=2'b11 with command 3'b000 → no Cmd_Valid, Mode_Reg unchanged. Assert Reset during tMRD wait → all outputs at reset values next cycle.
